id_queue_stage: RTL and testbench
=================================

Name: id_queue_stage

Overview:
- Parametrised successor to the combinational RV64I decoder.
- Buffers fetched instructions in a DEPTH-entry FIFO and decodes the FIFO head.
- Presents the decoded bundle through a registered valid/ready output stage.
- Supports RV32I/RV64I via XLEN; sits between IF and the regfile-read/EX stage, with flush for redirects.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64; immediates sign-extend to XLEN; RV64-only encodings are illegal when XLEN=32.
- DEPTH, 4, FIFO entries; power of two, >=2.
- PC_W, 64, width of the PC carried with each instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush_i  in  1  discards FIFO contents and the output stage.
- in_valid_i  in  1  instruction/PC present.
- in_ready_o  out  1  FIFO can accept this cycle.
- in_instr_i  in  32  raw instruction.
- in_pc_i  in  PC_W  instruction PC.
- out_valid_o  out  1  decoded bundle valid.
- out_ready_i  in  1  downstream accepts bundle.
- out_pc_o  out  PC_W  PC of the bundle.
- out_rs1_en_o / out_rs2_en_o / out_rd_en_o  out  1 each  operand/writeback enables.
- out_rs1_idx_o / out_rs2_idx_o / out_rd_idx_o  out  5 each  register indices.
- out_op_info_o  out  12  one-hot class {alu_imm, alu_imm_w, alu, alu_w, branch, jal, jalr, load, store, lui, auipc, system}, MSB first.
- out_fun3_o  out  3  instr[14:12].
- out_imm_o  out  XLEN  selected, sign-extended immediate.
- out_illegal_o / out_ecall_o / out_ebreak_o / out_mret_o  out  1 each  exception flags.
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_n=0 at clk edge): FIFO pointers and count_o = 0, out_valid_o = 0. All other outputs are 0. Reset mid-operation drops all instructions.
- Input handshake:
  - in_ready_o = (count_o != DEPTH) & ~flush_i.
  - A push occurs when in_valid_i & in_ready_o.
  - When full, there is no push even if a pop occurs the same cycle.
- Output stage:
  - A pop occurs when count_o != 0 & (~out_valid_o | out_ready_i) & ~flush_i.
  - On a pop, the decode of the FIFO head loads into the output register and out_valid_o = 1.
  - If out_valid_o & out_ready_i and there is no pop, out_valid_o falls to 0.
  - While out_valid_o & ~out_ready_i, all out_* signals hold stable.
- Latency: with the stage empty, an instruction pushed at edge N is visible with out_valid_o=1 after edge N+1. Sustained throughput is 1 per cycle.
- Simultaneous push and pop: count_o is unchanged; the pointers wrap modulo DEPTH.
- Flush: flush_i=1 at an edge sets count_o=0, resets the pointers and sets out_valid_o=0. Flush beats push and pop in the same cycle.
- Decode (combinational on the head, then registered):
  - Opcode classes, fun3/fun7 checks and system-instruction encodings are the standard RV32I/RV64I base set.
  - Immediate select:
    - I: alu_imm, alu_imm_w, load, jalr.
    - S: store.
    - B: branch.
    - J: jal.
    - U: lui OR auipc.
    - Otherwise 0.
- Enables:
  - rs1_en = 0 for lui, auipc, jal, csr*i, ecall, ebreak, mret, illegal.
  - rs2_en = 1 for alu, alu_w, branch, store only.
  - rd_en = 0 for branch, store, ecall, ebreak, mret, illegal, or rd==0.
- Illegal:
  - instr[1:0] != 2'b11.
  - Unknown opcode.
  - Branch fun3 010/011.
  - Load fun3 111.
  - Store fun3 >= 100.
  - Reg-reg fun7 not 0x00 (0x20 allowed only for sub/sra/subw/sraw).
  - Shift-imm upper bits invalid; RV64 slli/srli/srai check instr[31:26], *w variants check instr[31:25].
  - alu_w fun3 outside {000, 001, 101}.
  - alu_imm_w fun3 outside {000, 001, 101}.
  - System fun3=000 encodings other than ecall/ebreak/mret.
  - System fun3=100.
  - When XLEN=32: alu_imm_w, alu_w, ld, lwu, sd, and shamt[5]=1.
- Illegal bundle: out_op_info_o = 0 and all enables = 0. PC, indices and fun3 are still passed through.

Test Plan:
- Reset, then push addi x5,x1,-1 (0xFFF08293), out_ready_i=1 -> two edges later out_valid_o=1, rs1_idx=1, rd_idx=5, rd_en=1, rs2_en=0, out_imm_o=all ones, op_info=12'h800.
- Hold out_ready_i=0, push DEPTH+2 instructions -> in_ready_o=0 once count_o=DEPTH; the first bundle holds stable. Release -> all DEPTH+1 accepted instructions emerge in order, one per cycle, with no loss or duplication.
- lui x3,0x12345 (0x123451B7), XLEN=64 -> imm = 0x0000000012345000, rs1_en=0. Also lui with imm 0x80000 -> upper bits sign-fill to 0xFFFFFFFF80000000.
- Concurrent push/pop streaming across pointer wrap (20 instructions, DEPTH=4) -> count_o stays constant and PCs come out in sequence.
- flush_i pulsed with count_o=3 and out_valid_o=1 -> next cycle count_o=0 and out_valid_o=0; an instruction presented during the flush is not accepted.
- XLEN=32: addw (0x002080BB) -> illegal=1, op_info=0, rd_en=0. XLEN=64: same word -> legal, alu_w set. 0x00000073 -> ecall=1, rd_en=0, rs1_en=0.

Source files
------------

// File: rtl/id_queue_stage.sv
// id_queue_stage
// Instruction queue between fetch and operand read. Fetched words and their
// PCs are buffered in a DEPTH-entry FIFO; the FIFO head is decoded
// combinationally and the decoded bundle is captured into a registered
// valid/ready output stage. A flush (branch redirect) empties both the FIFO
// and the output stage. XLEN selects RV32I or RV64I decoding.
module id_queue_stage #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int PC_W  = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [31:0]               in_instr_i,
    input  logic [PC_W-1:0]           in_pc_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [PC_W-1:0]           out_pc_o,
    output logic                      out_rs1_en_o,
    output logic                      out_rs2_en_o,
    output logic                      out_rd_en_o,
    output logic [4:0]                out_rs1_idx_o,
    output logic [4:0]                out_rs2_idx_o,
    output logic [4:0]                out_rd_idx_o,
    output logic [11:0]               out_op_info_o,
    output logic [2:0]                out_fun3_o,
    output logic [XLEN-1:0]           out_imm_o,
    output logic                      out_illegal_o,
    output logic                      out_ecall_o,
    output logic                      out_ebreak_o,
    output logic                      out_mret_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam bit IS_RV32 = (XLEN == 32);

    // Major opcodes of the base integer ISA
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_W = 7'b0011011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_W     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // One-hot operation classes, MSB first
    localparam logic [11:0] CLS_ALU_IMM   = 12'h800;
    localparam logic [11:0] CLS_ALU_IMM_W = 12'h400;
    localparam logic [11:0] CLS_ALU       = 12'h200;
    localparam logic [11:0] CLS_ALU_W     = 12'h100;
    localparam logic [11:0] CLS_BRANCH    = 12'h080;
    localparam logic [11:0] CLS_JAL       = 12'h040;
    localparam logic [11:0] CLS_JALR      = 12'h020;
    localparam logic [11:0] CLS_LOAD      = 12'h010;
    localparam logic [11:0] CLS_STORE     = 12'h008;
    localparam logic [11:0] CLS_LUI       = 12'h004;
    localparam logic [11:0] CLS_AUIPC     = 12'h002;
    localparam logic [11:0] CLS_SYSTEM    = 12'h001;

    // Fixed encodings of the privileged system instructions
    localparam logic [31:0] ENC_ECALL  = 32'h0000_0073;
    localparam logic [31:0] ENC_EBREAK = 32'h0010_0073;
    localparam logic [31:0] ENC_MRET   = 32'h3020_0073;

    // ------------------------------------------------------------------
    // FIFO storage and control
    // ------------------------------------------------------------------
    logic [31:0]      instr_mem_q [DEPTH];
    logic [PC_W-1:0]  pc_mem_q    [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q;
    logic             push;
    logic             pop;
    logic [31:0]      head_instr;
    logic [PC_W-1:0]  head_pc;

    // A full FIFO refuses input even when the head leaves in the same cycle,
    // which keeps in_ready_o independent of the downstream ready.
    assign in_ready_o = (count_q != FULL_CNT) & ~flush_i;
    assign push       = in_valid_i & in_ready_o;
    assign pop        = (count_q != '0) & (~out_valid_q | out_ready_i) & ~flush_i;

    assign head_instr = instr_mem_q[rd_ptr_q];
    assign head_pc    = pc_mem_q[rd_ptr_q];
    assign count_o    = count_q;

    // Pointer and occupancy next-state; flush empties the queue outright
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset because occupancy gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= in_instr_i;
            pc_mem_q[wr_ptr_q]    <= in_pc_i;
        end
    end

    // ------------------------------------------------------------------
    // Decode of the FIFO head
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      fun3;
    logic [6:0]      fun7;
    logic [11:0]     cls;
    logic            bad;
    logic            legal;
    logic            is_ecall;
    logic            is_ebreak;
    logic            is_mret;
    logic            fun3_w_ok;
    logic            fun7_rr_ok;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    logic [11:0]     op_info_d;
    logic            rs1_en_d, rs2_en_d, rd_en_d;
    logic [XLEN-1:0] imm_d;
    logic            ecall_d, ebreak_d, mret_d;

    assign opcode = head_instr[6:0];
    assign fun3   = head_instr[14:12];
    assign fun7   = head_instr[31:25];

    // The *w forms only exist for add/shift; the 0x20 funct7 selects sub/sra
    assign fun3_w_ok  = (fun3 == 3'b000) | (fun3 == 3'b001) | (fun3 == 3'b101);
    assign fun7_rr_ok = (fun7 == 7'h00) |
                        ((fun7 == 7'h20) & ((fun3 == 3'b000) | (fun3 == 3'b101)));

    // Immediate formats, each sign-extended to the datapath width
    assign imm_i = XLEN'($signed(head_instr[31:20]));
    assign imm_s = XLEN'($signed({head_instr[31:25], head_instr[11:7]}));
    assign imm_b = XLEN'($signed({head_instr[31], head_instr[7], head_instr[30:25],
                                  head_instr[11:8], 1'b0}));
    assign imm_j = XLEN'($signed({head_instr[31], head_instr[19:12], head_instr[20],
                                  head_instr[30:21], 1'b0}));
    assign imm_u = XLEN'($signed({head_instr[31:12], 12'h000}));

    // Classify the opcode and collect every reason the word is not legal
    always_comb begin
        cls       = '0;
        bad       = (head_instr[1:0] != 2'b11);
        is_ecall  = 1'b0;
        is_ebreak = 1'b0;
        is_mret   = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                cls = CLS_ALU_IMM;
                // RV64 shifts use a 6-bit shamt; RV32 must keep shamt[5] clear
                if (fun3 == 3'b001) begin
                    bad = bad | (IS_RV32 ? (fun7 != 7'h00) : (head_instr[31:26] != 6'h00));
                end
                if (fun3 == 3'b101) begin
                    bad = bad | (IS_RV32 ? ((fun7 != 7'h00) & (fun7 != 7'h20))
                                         : ((head_instr[31:26] != 6'h00) &
                                            (head_instr[31:26] != 6'h10)));
                end
            end
            OPC_OP_IMM_W: begin
                cls = CLS_ALU_IMM_W;
                bad = bad | IS_RV32 | ~fun3_w_ok;
                if (fun3 == 3'b001) begin
                    bad = bad | (fun7 != 7'h00);
                end
                if (fun3 == 3'b101) begin
                    bad = bad | ((fun7 != 7'h00) & (fun7 != 7'h20));
                end
            end
            OPC_OP: begin
                cls = CLS_ALU;
                bad = bad | ~fun7_rr_ok;
            end
            OPC_OP_W: begin
                cls = CLS_ALU_W;
                bad = bad | IS_RV32 | ~fun3_w_ok | ~fun7_rr_ok;
            end
            OPC_BRANCH: begin
                cls = CLS_BRANCH;
                bad = bad | (fun3 == 3'b010) | (fun3 == 3'b011);
            end
            OPC_JAL: begin
                cls = CLS_JAL;
            end
            OPC_JALR: begin
                cls = CLS_JALR;
                bad = bad | (fun3 != 3'b000);
            end
            OPC_LOAD: begin
                cls = CLS_LOAD;
                bad = bad | (fun3 == 3'b111) |
                      (IS_RV32 & ((fun3 == 3'b011) | (fun3 == 3'b110)));
            end
            OPC_STORE: begin
                cls = CLS_STORE;
                bad = bad | fun3[2] | (IS_RV32 & (fun3 == 3'b011));
            end
            OPC_LUI: begin
                cls = CLS_LUI;
            end
            OPC_AUIPC: begin
                cls = CLS_AUIPC;
            end
            OPC_SYSTEM: begin
                cls = CLS_SYSTEM;
                if (fun3 == 3'b000) begin
                    is_ecall  = (head_instr == ENC_ECALL);
                    is_ebreak = (head_instr == ENC_EBREAK);
                    is_mret   = (head_instr == ENC_MRET);
                    bad       = bad | ~(is_ecall | is_ebreak | is_mret);
                end
                if (fun3 == 3'b100) begin
                    bad = 1'b1;
                end
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

    // Derive the bundle fields; an illegal word carries no class or enables
    always_comb begin
        legal     = (cls != '0) & ~bad;
        op_info_d = legal ? cls : 12'h000;
        rs1_en_d  = legal & ~((cls == CLS_LUI) | (cls == CLS_AUIPC) | (cls == CLS_JAL) |
                              ((cls == CLS_SYSTEM) & (fun3[2] | (fun3 == 3'b000))));
        rs2_en_d  = legal & ((cls == CLS_ALU) | (cls == CLS_ALU_W) |
                             (cls == CLS_BRANCH) | (cls == CLS_STORE));
        rd_en_d   = legal & (head_instr[11:7] != 5'd0) &
                    ~((cls == CLS_BRANCH) | (cls == CLS_STORE) |
                      ((cls == CLS_SYSTEM) & (fun3 == 3'b000)));
        ecall_d   = legal & is_ecall;
        ebreak_d  = legal & is_ebreak;
        mret_d    = legal & is_mret;
        imm_d     = '0;
        if (legal) begin
            case (cls)
                CLS_ALU_IMM, CLS_ALU_IMM_W, CLS_LOAD, CLS_JALR: imm_d = imm_i;
                CLS_STORE:                                      imm_d = imm_s;
                CLS_BRANCH:                                     imm_d = imm_b;
                CLS_JAL:                                        imm_d = imm_j;
                CLS_LUI, CLS_AUIPC:                             imm_d = imm_u;
                default:                                        imm_d = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered output stage
    // ------------------------------------------------------------------
    logic [PC_W-1:0] pc_q;
    logic            rs1_en_q, rs2_en_q, rd_en_q;
    logic [4:0]      rs1_idx_q, rs2_idx_q, rd_idx_q;
    logic [11:0]     op_info_q;
    logic [2:0]      fun3_q;
    logic [XLEN-1:0] imm_q;
    logic            illegal_q, ecall_q, ebreak_q, mret_q;

    // Load the decoded head on a pop; otherwise hold, dropping valid once taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            rs1_en_q    <= 1'b0;
            rs2_en_q    <= 1'b0;
            rd_en_q     <= 1'b0;
            rs1_idx_q   <= '0;
            rs2_idx_q   <= '0;
            rd_idx_q    <= '0;
            op_info_q   <= '0;
            fun3_q      <= '0;
            imm_q       <= '0;
            illegal_q   <= 1'b0;
            ecall_q     <= 1'b0;
            ebreak_q    <= 1'b0;
            mret_q      <= 1'b0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            pc_q        <= head_pc;
            rs1_en_q    <= rs1_en_d;
            rs2_en_q    <= rs2_en_d;
            rd_en_q     <= rd_en_d;
            rs1_idx_q   <= head_instr[19:15];
            rs2_idx_q   <= head_instr[24:20];
            rd_idx_q    <= head_instr[11:7];
            op_info_q   <= op_info_d;
            fun3_q      <= fun3;
            imm_q       <= imm_d;
            illegal_q   <= ~legal;
            ecall_q     <= ecall_d;
            ebreak_q    <= ebreak_d;
            mret_q      <= mret_d;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_pc_o      = pc_q;
    assign out_rs1_en_o  = rs1_en_q;
    assign out_rs2_en_o  = rs2_en_q;
    assign out_rd_en_o   = rd_en_q;
    assign out_rs1_idx_o = rs1_idx_q;
    assign out_rs2_idx_o = rs2_idx_q;
    assign out_rd_idx_o  = rd_idx_q;
    assign out_op_info_o = op_info_q;
    assign out_fun3_o    = fun3_q;
    assign out_imm_o     = imm_q;
    assign out_illegal_o = illegal_q;
    assign out_ecall_o   = ecall_q;
    assign out_ebreak_o  = ebreak_q;
    assign out_mret_o    = mret_q;

endmodule

// File: tb/tb_id_queue_stage.sv
// Bench for id_queue_stage: an RV64 and an RV32 instance share one stimulus
// stream and are compared against a queue-based reference model.
module tb_id_queue_stage;

    localparam int DEPTH = 4;
    localparam int PC_W  = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush_i, in_valid_i, out_ready_i;
    logic [31:0] in_instr_i;
    logic [63:0] in_pc_i;

    logic        a_in_ready, a_ov, a_rs1_en, a_rs2_en, a_rd_en;
    logic [63:0] a_pc;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [11:0] a_op;
    logic [2:0]  a_f3, a_cnt;
    logic [63:0] a_imm;
    logic        a_ill, a_ecall, a_ebreak, a_mret;

    logic        b_in_ready, b_ov, b_rs1_en, b_rs2_en, b_rd_en;
    logic [63:0] b_pc;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [11:0] b_op;
    logic [2:0]  b_f3, b_cnt;
    logic [31:0] b_imm;
    logic        b_ill, b_ecall, b_ebreak, b_mret;

    id_queue_stage #(.XLEN(64), .DEPTH(DEPTH), .PC_W(PC_W)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(a_in_ready),
        .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
        .out_valid_o(a_ov), .out_ready_i(out_ready_i), .out_pc_o(a_pc),
        .out_rs1_en_o(a_rs1_en), .out_rs2_en_o(a_rs2_en), .out_rd_en_o(a_rd_en),
        .out_rs1_idx_o(a_rs1), .out_rs2_idx_o(a_rs2), .out_rd_idx_o(a_rd),
        .out_op_info_o(a_op), .out_fun3_o(a_f3), .out_imm_o(a_imm),
        .out_illegal_o(a_ill), .out_ecall_o(a_ecall), .out_ebreak_o(a_ebreak),
        .out_mret_o(a_mret), .count_o(a_cnt)
    );

    id_queue_stage #(.XLEN(32), .DEPTH(DEPTH), .PC_W(PC_W)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(b_in_ready),
        .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
        .out_valid_o(b_ov), .out_ready_i(out_ready_i), .out_pc_o(b_pc),
        .out_rs1_en_o(b_rs1_en), .out_rs2_en_o(b_rs2_en), .out_rd_en_o(b_rd_en),
        .out_rs1_idx_o(b_rs1), .out_rs2_idx_o(b_rs2), .out_rd_idx_o(b_rd),
        .out_op_info_o(b_op), .out_fun3_o(b_f3), .out_imm_o(b_imm),
        .out_illegal_o(b_ill), .out_ecall_o(b_ecall), .out_ebreak_o(b_ebreak),
        .out_mret_o(b_mret), .count_o(b_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [11:0] op;
        logic        rs1_en, rs2_en, rd_en;
        logic [63:0] imm;
        logic        ill, ecall, ebreak, mret;
    } dec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } entry_t;

    entry_t mq[$];
    entry_t m_out;
    bit     m_ov;
    logic [63:0] pc_next = 64'h1000;

    // Class index follows the op_info list: 0=alu_imm ... 11=system
    function automatic dec_t ref_decode(input logic [31:0] w, input bit rv32);
        dec_t d;
        int cls, fmt;
        bit bad, legal;
        logic [2:0] f3;
        logic [6:0] f7;
        longint v;
        d = '0;
        f3 = w[14:12];
        f7 = w[31:25];
        case (w[6:0])
            7'h13: cls = 0;   7'h1B: cls = 1;   7'h33: cls = 2;   7'h3B: cls = 3;
            7'h63: cls = 4;   7'h6F: cls = 5;   7'h67: cls = 6;   7'h03: cls = 7;
            7'h23: cls = 8;   7'h37: cls = 9;   7'h17: cls = 10;  7'h73: cls = 11;
            default: cls = -1;
        endcase
        bad = (w[1:0] != 2'b11) || (cls < 0);
        case (cls)
            0: begin
                if (f3 == 3'd1) bad |= rv32 ? (f7 != 7'h00) : (w[31:26] != 6'h00);
                if (f3 == 3'd5) bad |= rv32 ? !(f7 inside {7'h00, 7'h20})
                                            : !(w[31:26] inside {6'h00, 6'h10});
            end
            1: bad |= rv32 || !(f3 inside {3'd0, 3'd1, 3'd5}) ||
                      (f3 == 3'd1 && f7 != 7'h00) ||
                      (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20}));
            2: bad |= !(f7 == 7'h00 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}));
            3: bad |= rv32 || !(f3 inside {3'd0, 3'd1, 3'd5}) ||
                      !(f7 == 7'h00 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}));
            4: bad |= f3 inside {3'd2, 3'd3};
            6: bad |= (f3 != 3'd0);
            7: bad |= (f3 == 3'd7) || (rv32 && f3 inside {3'd3, 3'd6});
            8: bad |= (f3 >= 3'd4) || (rv32 && f3 == 3'd3);
            11: begin
                if (f3 == 3'd4) bad = 1;
                else if (f3 == 3'd0) begin
                    if (w == 32'h0000_0073)      d.ecall  = 1;
                    else if (w == 32'h0010_0073) d.ebreak = 1;
                    else if (w == 32'h3020_0073) d.mret   = 1;
                    else bad = 1;
                end
            end
            default: ;
        endcase
        legal = !bad;
        if (!legal) begin
            d.ecall = 0; d.ebreak = 0; d.mret = 0;
        end
        d.ill = !legal;
        d.op  = legal ? (12'h800 >> cls) : 12'h000;
        d.rs2_en = legal && (cls inside {2, 3, 4, 8});
        d.rs1_en = legal && !(cls inside {5, 9, 10}) &&
                   !(cls == 11 && (f3 == 3'd0 || f3 >= 3'd4));
        d.rd_en  = legal && (w[11:7] != 0) && !(cls inside {4, 8}) &&
                   !(cls == 11 && f3 == 3'd0);
        // fmt: 1=I 2=S 3=B 4=J 5=U
        case (cls)
            0, 1, 6, 7: fmt = 1;
            8:          fmt = 2;
            4:          fmt = 3;
            5:          fmt = 4;
            9, 10:      fmt = 5;
            default:    fmt = 0;
        endcase
        v = 0;
        case (fmt)
            1: begin v = longint'(w[31:20]); if (v >= 2048) v -= 4096; end
            2: begin v = longint'({w[31:25], w[11:7]}); if (v >= 2048) v -= 4096; end
            3: begin
                v = longint'({w[31], w[7], w[30:25], w[11:8], 1'b0});
                if (v >= 4096) v -= 8192;
            end
            4: begin
                v = longint'({w[31], w[19:12], w[20], w[30:21], 1'b0});
                if (v >= 1048576) v -= 2097152;
            end
            5: begin
                v = longint'(w[31:12]) * 4096;
                if (w[31]) v = v - (longint'(1) << 32);
            end
            default: v = 0;
        endcase
        d.imm = legal ? 64'(v) : 64'h0;
        return d;
    endfunction

    task automatic check_outputs();
        dec_t e64, e32;
        check_val("count64", 64'(a_cnt), 64'(mq.size()));
        check_val("count32", 64'(b_cnt), 64'(mq.size()));
        check_val("valid64", 64'(a_ov), 64'(m_ov));
        check_val("valid32", 64'(b_ov), 64'(m_ov));
        if (m_ov) begin
            e64 = ref_decode(m_out.instr, 1'b0);
            e32 = ref_decode(m_out.instr, 1'b1);
            check_val("pc64", a_pc, m_out.pc);
            check_val("pc32", b_pc, m_out.pc);
            check_val("idx64", 64'({a_rs1, a_rs2, a_rd, a_f3}),
                      64'({m_out.instr[19:15], m_out.instr[24:20], m_out.instr[11:7], m_out.instr[14:12]}));
            check_val("idx32", 64'({b_rs1, b_rs2, b_rd, b_f3}),
                      64'({m_out.instr[19:15], m_out.instr[24:20], m_out.instr[11:7], m_out.instr[14:12]}));
            check_val("op64", 64'(a_op), 64'(e64.op));
            check_val("op32", 64'(b_op), 64'(e32.op));
            check_val("en64", 64'({a_rs1_en, a_rs2_en, a_rd_en}), 64'({e64.rs1_en, e64.rs2_en, e64.rd_en}));
            check_val("en32", 64'({b_rs1_en, b_rs2_en, b_rd_en}), 64'({e32.rs1_en, e32.rs2_en, e32.rd_en}));
            check_val("imm64", a_imm, e64.imm);
            check_val("imm32", 64'(b_imm), 64'(e32.imm[31:0]));
            check_val("flags64", 64'({a_ill, a_ecall, a_ebreak, a_mret}),
                      64'({e64.ill, e64.ecall, e64.ebreak, e64.mret}));
            check_val("flags32", 64'({b_ill, b_ecall, b_ebreak, b_mret}),
                      64'({e32.ill, e32.ecall, e32.ebreak, e32.mret}));
        end
    endtask

    // One clock: drive at the falling edge, step the model at the rising edge,
    // compare at the next falling edge.
    task automatic cycle(input bit r, input bit fl, input bit iv,
                         input logic [31:0] ins, input bit ordy);
        bit exp_ready, do_push, do_pop;
        entry_t e;
        rst_n       = r;
        flush_i     = fl;
        in_valid_i  = iv;
        in_instr_i  = ins;
        in_pc_i     = pc_next;
        out_ready_i = ordy;
        #1;
        exp_ready = (mq.size() != DEPTH) && !fl;
        check_val("in_ready64", 64'(a_in_ready), 64'(exp_ready));
        check_val("in_ready32", 64'(b_in_ready), 64'(exp_ready));
        do_push = iv && exp_ready;
        do_pop  = (mq.size() != 0) && (!m_ov || ordy) && !fl;
        e.instr = ins;
        e.pc    = pc_next;
        @(posedge clk);
        if (!r || fl) begin
            mq.delete();
            m_ov = 0;
        end else begin
            if (do_pop) begin
                m_out = mq.pop_front();
                m_ov  = 1;
            end else if (m_ov && ordy) begin
                m_ov = 0;
            end
            if (do_push) mq.push_back(e);
        end
        if (iv) pc_next += 4;
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 15);
        case (k)
            0: w[6:0] = 7'h13;  1: w[6:0] = 7'h1B;  2: w[6:0] = 7'h33;  3: w[6:0] = 7'h3B;
            4: w[6:0] = 7'h63;  5: w[6:0] = 7'h6F;  6: w[6:0] = 7'h67;  7: w[6:0] = 7'h03;
            8: w[6:0] = 7'h23;  9: w[6:0] = 7'h37; 10: w[6:0] = 7'h17; 11: w[6:0] = 7'h73;
            12: w[6:0] = 7'h0F;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        if (w[6:0] == 7'h13 && $urandom_range(0, 1) == 1)
            w[31:26] = ($urandom_range(0, 1) == 1) ? 6'h10 : 6'h00;
        if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 2))
                0: w = 32'h0000_0073;
                1: w = 32'h0010_0073;
                default: w = 32'h3020_0073;
            endcase
        end
        return w;
    endfunction

    initial begin
        rst_n = 0; flush_i = 0; in_valid_i = 0; in_instr_i = '0; in_pc_i = '0; out_ready_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // Reset state: everything zero, queue empty and ready
        check_val("rst_count", 64'(a_cnt), 64'd0);
        check_val("rst_valid", 64'({a_ov, b_ov}), 64'd0);
        check_val("rst_pc", a_pc, 64'd0);
        check_val("rst_op", 64'(a_op), 64'd0);
        check_val("rst_imm", a_imm, 64'd0);
        check_val("rst_misc", 64'({a_rs1_en, a_rs2_en, a_rd_en, a_ill, a_ecall, a_ebreak, a_mret, a_rd}), 64'd0);
        check_val("rst_ready", 64'({a_in_ready, b_in_ready}), 64'd3);

        // addi x5,x1,-1 appears after the second edge
        cycle(1, 0, 1, 32'hFFF0_8293, 1);
        check_val("addi_early", 64'(a_ov), 64'd0);
        cycle(1, 0, 0, 32'h0, 1);
        check_val("addi_valid", 64'(a_ov), 64'd1);
        check_val("addi_idx", 64'({a_rs1, a_rd}), 64'({5'd1, 5'd5}));
        check_val("addi_en", 64'({a_rs1_en, a_rs2_en, a_rd_en}), 64'b101);
        check_val("addi_imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check_val("addi_imm32", 64'(b_imm), 64'hFFFF_FFFF);
        check_val("addi_op", 64'(a_op), 64'h800);
        cycle(1, 0, 0, 32'h0, 1);

        // lui with positive and sign-filling immediates
        cycle(1, 0, 1, 32'h1234_51B7, 1);
        cycle(1, 0, 1, 32'h8000_01B7, 1);
        check_val("lui_imm", a_imm, 64'h0000_0000_1234_5000);
        check_val("lui_rs1en", 64'(a_rs1_en), 64'd0);
        check_val("lui_op", 64'(a_op), 64'h004);
        cycle(1, 0, 0, 32'h0, 1);
        check_val("lui_neg", a_imm, 64'hFFFF_FFFF_8000_0000);
        check_val("lui_neg32", 64'(b_imm), 64'h8000_0000);
        cycle(1, 0, 0, 32'h0, 1);

        // Back-pressure: DEPTH+2 offered, DEPTH+1 accepted, bundle held
        for (int i = 0; i < DEPTH + 2; i++) cycle(1, 0, 1, gen_instr(), 0);
        check_val("full_count", 64'(a_cnt), 64'(DEPTH));
        check_val("full_ready", 64'(a_in_ready), 64'd0);
        for (int i = 0; i < DEPTH + 2; i++) cycle(1, 0, 0, 32'h0, 1);
        check_val("drain_count", 64'(a_cnt), 64'd0);

        // Flush with three queued and a valid bundle; the offered word is dropped
        for (int i = 0; i < 4; i++) cycle(1, 0, 1, gen_instr(), 0);
        check_val("preflush", 64'({a_cnt, a_ov}), 64'({3'd3, 1'b1}));
        cycle(1, 1, 1, gen_instr(), 0);
        check_val("flush_state", 64'({a_cnt, a_ov, b_cnt, b_ov}), 64'd0);
        cycle(1, 0, 0, 32'h0, 1);
        check_val("flush_noaccept", 64'(a_cnt), 64'd0);

        // addw: legal on RV64, illegal on RV32; then ecall
        cycle(1, 0, 1, 32'h0020_80BB, 1);
        cycle(1, 0, 1, 32'h0000_0073, 1);
        check_val("addw64_op", 64'({a_op, a_ill}), 64'({12'h100, 1'b0}));
        check_val("addw32_ill", 64'({b_ill, b_op, b_rd_en}), 64'({1'b1, 12'h000, 1'b0}));
        cycle(1, 0, 0, 32'h0, 1);
        check_val("ecall_flag", 64'({a_ecall, b_ecall}), 64'b11);
        check_val("ecall_en", 64'({a_rd_en, a_rs1_en}), 64'd0);
        check_val("ecall_op", 64'(a_op), 64'h001);

        // Streaming across pointer wrap
        for (int i = 0; i < 20; i++) cycle(1, 0, 1, gen_instr(), 1);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 32'h0, 1);

        // Randomised traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 3),
                  ($urandom_range(0, 99) < 70), gen_instr(), ($urandom_range(0, 99) < 65));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
